// File: rtl/calc_seg_scan.sv
// calc_seg_scan: multiplexed 8-digit common-anode 7-segment scanner for the
// 32-bit calculator result bus. One digit is lit per SCAN_DIV-cycle slot.
// The value is snapshotted at each frame boundary (transition into digit 0)
// so the digits of a frame always come from one coherent value.
// Optional build macro: CALC_SEG_LZ_BLANK_EN enables leading-zero blanking
// of digits 1..7 (digit 0 is always shown).
module calc_seg_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cal_result,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int              CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [31:0]   snap;

  logic          tick;
  logic          frame_edge;
  logic [2:0]    idx_next;
  logic [31:0]   frame_value;
  logic [3:0]    nibble;
  logic          blank;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;

  assign tick        = (div_cnt == CNT_MAX);
  assign idx_next    = idx + 3'd1;
  assign frame_edge  = tick && (idx == 3'd7);
  // Digit 0 of a new frame decodes from the value being captured right now,
  // not from the stale snapshot.
  assign frame_value = frame_edge ? cal_result : snap;
  assign dp          = 1'b1;

  // Decode the digit that becomes active on the next tick.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    blank    = 1'b0;
    nibble   = frame_value[{idx_next, 2'b00} +: 4];
`ifdef CALC_SEG_LZ_BLANK_EN
    blank    = (idx_next != 3'd0) && ((frame_value >> {idx_next, 2'b00}) == 32'd0);
`endif
    an_next  = blank ? 8'hFF : ~(8'd1 << idx_next);
    seg_next = blank ? 7'h7F : hex_to_seg(nibble);
  end

  // Slot divider: counts 0..SCAN_DIV-1 and wraps; tick marks the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Digit index, frame snapshot and registered pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 3'd0;
      // NOTE: the snapshot is reset because the display must read 0 before
      // the first frame boundary; it is a register, not a memory array.
      snap        <= 32'd0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (tick) begin
        idx <= idx_next;
        an  <= an_next;
        seg <= seg_next;
      end
      if (frame_edge) snap <= cal_result;
    end
  end

endmodule

// File: tb/tb_calc_seg_scan.sv
// Self-checking bench for calc_seg_scan (SCAN_DIV=4). A behavioural model
// counts cycles and ticks since reset release and derives the lit digit and
// frame value arithmetically; a compare process checks every cycle on the
// falling edge. Directed sections pin the model with hand-computed literals.
module tb_calc_seg_scan;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] cal_result;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int vectors;
  int miscompares;

  calc_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cal_result  (cal_result),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16];
  initial begin
    hex_tbl[0]  = 7'b1000000; hex_tbl[1]  = 7'b1111001;
    hex_tbl[2]  = 7'b0100100; hex_tbl[3]  = 7'b0110000;
    hex_tbl[4]  = 7'b0011001; hex_tbl[5]  = 7'b0010010;
    hex_tbl[6]  = 7'b0000010; hex_tbl[7]  = 7'b1111000;
    hex_tbl[8]  = 7'b0000000; hex_tbl[9]  = 7'b0010000;
    hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b0000011;
    hex_tbl[12] = 7'b1000110; hex_tbl[13] = 7'b0100001;
    hex_tbl[14] = 7'b0000110; hex_tbl[15] = 7'b0001110;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since release, ticks since release, current frame value.
  int          m_cyc;
  int          m_ticks;
  logic [31:0] m_frame;
  logic        m_fs;

  // Model update on the same edges as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   <= 0;
      m_ticks <= 0;
      m_frame <= 32'd0;
      m_fs    <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_fs  <= 1'b0;
      if ((m_cyc + 1) % SCAN_DIV == 0) begin
        m_ticks <= m_ticks + 1;
        if ((m_ticks + 1) % 8 == 0) begin
          m_frame <= cal_result;
          m_fs    <= 1'b1;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT pins against the model.
  always @(negedge clk) begin
    int          d;
    logic [31:0] v;
    logic        blank;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    if (m_ticks == 0) begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      d     = m_ticks % 8;
      v     = m_frame >> (4 * d);
      blank = 1'b0;
`ifdef CALC_SEG_LZ_BLANK_EN
      blank = (d != 0) && (v == 32'd0);
`endif
      exp_an  = blank ? 8'hFF : ~(8'd1 << d);
      exp_seg = blank ? 7'h7F : hex_tbl[v[3:0]];
    end
    check("model_an",  {24'd0, an},  {24'd0, exp_an});
    check("model_seg", {25'd0, seg}, {25'd0, exp_seg});
    check("model_fs",  {31'd0, frame_start}, {31'd0, m_fs});
    check("dp_off",    {31'd0, dp}, 32'd1);
  end

  // Wait (bounded) until an equals target; returns seg seen then.
  task automatic wait_an(input string name, input logic [7:0] target, output logic [6:0] s);
    bit hit;
    hit = 1'b0;
    s   = 7'h7F;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk);
      if (an == target) begin
        hit = 1'b1;
        s   = seg;
      end
    end
    check({name, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  // Wait (bounded) for a frame_start pulse; returns cycles waited.
  task automatic wait_fs(input string name, output int cycles);
    bit hit;
    hit    = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 80 && !hit; i++) begin
      @(negedge clk);
      if (frame_start) begin
        hit    = 1'b1;
        cycles = i;
      end
    end
    check({name, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    logic [6:0] s;
    int         k;
    int         pulses;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cal_result  = 32'd0;

    // 1. Reset values and first-tick latency.
    repeat (3) @(negedge clk);
    check("rst_an",  {24'd0, an},  32'hFF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_fs",  {31'd0, frame_start}, 32'd0);
    rst_n = 1'b1;
`ifndef CALC_SEG_LZ_BLANK_EN
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (an != 8'hFF) k = i;
    end
    check("first_tick_latency", k, 4);
    check("first_an", {24'd0, an}, 32'hFD);
    check("first_seg_zero", {25'd0, seg}, 32'h40);
`endif

    // 2. Zero value across two frames (model checks the an walk).
    repeat (64) @(negedge clk);

    // 3. 1234_ABCD after a frame boundary.
    cal_result = 32'h1234_ABCD;
    wait_fs("fs_abcd", k);
    check("abcd_d0_an", {24'd0, an}, 32'hFE);
    check("abcd_d0",    {25'd0, seg}, 32'h21);
    wait_an("abcd_d1", 8'hFD, s); check("abcd_d1", {25'd0, s}, 32'h46);
    wait_an("abcd_d4", 8'hEF, s); check("abcd_d4", {25'd0, s}, 32'h19);
    wait_an("abcd_d7", 8'h7F, s); check("abcd_d7", {25'd0, s}, 32'h79);

    // 4. Mid-frame change shows only from the next frame.
    cal_result = 32'h0000_0011;
    wait_fs("fs_11", k);
    wait_an("idx3", 8'hF7, s);
    cal_result = 32'h0000_0022;
    wait_fs("fs_22", k);
    check("p22_d0", {25'd0, seg}, 32'h24);
    wait_an("p22_d1", 8'hFD, s); check("p22_d1", {25'd0, s}, 32'h24);
    pulses = 0;
    repeat (64) begin
      @(negedge clk);
      if (frame_start) pulses++;
    end
    check("fs_per_64clk", pulses, 2);

    // Randomized values, changed at random points; model checks every cycle.
    repeat (40) begin
      cal_result = $urandom;
      if ($urandom_range(0, 3) == 0) cal_result = cal_result >> (4 * $urandom_range(1, 7));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    // 5. Async reset while idx=5, then restart from idx 0 with snap=0.
    cal_result = 32'h0000_0000;
    wait_fs("fs_pre_rst", k);
    wait_an("idx5", 8'hDF, s);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an",  {24'd0, an},  32'hFF);
    check("async_rst_seg", {25'd0, seg}, 32'h7F);
    cal_result = 32'h5555_5555;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fs("fs_after_rst", k);
    check("first_frame_latency", k, 8 * SCAN_DIV);
    check("post_rst_d0", {25'd0, seg}, 32'h12);

    // 6. Leading-zero behaviour with 0000_0A05.
    cal_result = 32'h0000_0A05;
    wait_fs("fs_a05", k);
    check("a05_d0", {25'd0, seg}, 32'h12);
    wait_an("a05_d2", 8'hFB, s); check("a05_d2", {25'd0, s}, 32'h08);
`ifdef CALC_SEG_LZ_BLANK_EN
    repeat (SCAN_DIV) @(negedge clk);
    check("a05_d3_blank", {24'd0, an}, 32'hFF);
`else
    wait_an("a05_d3", 8'hF7, s); check("a05_d3", {25'd0, s}, 32'h40);
`endif
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
